// File: rtl/memory_access.sv
// Memory-access stage: word loads/stores against a local data memory
// with fixed multi-cycle latency, producing a registered MA/WB bundle.
package core_pkg;

    typedef struct packed {
        logic       isLd;
        logic       isSt;
        logic       isWb;
        logic       isBr;
        logic [3:0] aluOp;
    } control_signal;

endpackage

module memory_access
    import core_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int DMEM_DEPTH  = 1024,
    parameter int MEM_LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] pc_in,
    input  logic [INSTR_WIDTH-1:0] aluResult_in,
    input  logic [INSTR_WIDTH-1:0] op2_in,
    input  logic [ADDR_WIDTH-1:0]  rd_in,
    input  control_signal          ctrl_sig_in,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] pc_out,
    output logic [INSTR_WIDTH-1:0] aluResult,
    output logic [INSTR_WIDTH-1:0] ldResult,
    output logic [ADDR_WIDTH-1:0]  rd,
    output control_signal          ctrl_sig_reg
);

    localparam int   IW    = $clog2(DMEM_DEPTH);
    localparam int   CW    = $clog2(MEM_LATENCY) + 1;
    localparam logic MULTI = (MEM_LATENCY > 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [INSTR_WIDTH-1:0] pc_h_q, pc_h_d;
    logic [INSTR_WIDTH-1:0] alu_h_q, alu_h_d;
    logic [INSTR_WIDTH-1:0] op2_h_q, op2_h_d;
    logic [ADDR_WIDTH-1:0]  rd_h_q, rd_h_d;
    control_signal          ctrl_h_q, ctrl_h_d;

    logic                   out_valid_q, out_valid_d;
    logic [INSTR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [INSTR_WIDTH-1:0] alu_q, alu_d;
    logic [INSTR_WIDTH-1:0] ld_q, ld_d;
    logic [ADDR_WIDTH-1:0]  rd_q, rd_d;
    control_signal          ctrl_q, ctrl_d;

    logic [INSTR_WIDTH-1:0] mem_q [DMEM_DEPTH];

    logic                   busy;
    logic                   accept;
    logic                   mem_op;
    logic                   done;
    logic                   mem_we;
    logic [INSTR_WIDTH-1:0] src_pc;
    logic [INSTR_WIDTH-1:0] src_alu;
    logic [INSTR_WIDTH-1:0] src_op2;
    logic [ADDR_WIDTH-1:0]  src_rd;
    control_signal          src_ctrl;
    logic [IW-1:0]          idx;
    logic                   unused_addr;

    assign busy     = (state_q == BUSY);
    assign in_ready = !busy && !rst;
    assign accept   = in_valid && in_ready;

    // Single-cycle completions use the live inputs; multi-cycle ones the hold regs.
    assign src_pc   = busy ? pc_h_q   : pc_in;
    assign src_alu  = busy ? alu_h_q  : aluResult_in;
    assign src_op2  = busy ? op2_h_q  : op2_in;
    assign src_rd   = busy ? rd_h_q   : rd_in;
    assign src_ctrl = busy ? ctrl_h_q : ctrl_sig_in;

    assign mem_op = src_ctrl.isLd || src_ctrl.isSt;
    assign idx    = src_alu[IW+1:2];
    assign done   = busy ? (cnt_q == CW'(1))
                         : (accept && (!mem_op || !MULTI));
    assign mem_we = done && src_ctrl.isSt && !src_ctrl.isLd;

    assign unused_addr = ^{src_alu[1:0], src_alu[INSTR_WIDTH-1:IW+2]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_h_d      = pc_h_q;
        alu_h_d     = alu_h_q;
        op2_h_d     = op2_h_q;
        rd_h_d      = rd_h_q;
        ctrl_h_d    = ctrl_h_q;
        out_valid_d = 1'b0;
        pc_out_d    = pc_out_q;
        alu_d       = alu_q;
        ld_d        = ld_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;

        if (accept) begin
            pc_h_d   = pc_in;
            alu_h_d  = aluResult_in;
            op2_h_d  = op2_in;
            rd_h_d   = rd_in;
            ctrl_h_d = ctrl_sig_in;
            if (mem_op && MULTI) begin
                state_d = BUSY;
                cnt_d   = CW'(MEM_LATENCY - 1);
            end
        end

        if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
            end
        end

        if (done) begin
            out_valid_d = 1'b1;
            pc_out_d    = src_pc;
            alu_d       = src_alu;
            rd_d        = src_rd;
            ctrl_d      = src_ctrl;
            if (src_ctrl.isLd) begin
                ld_d = mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_h_q      <= '0;
            alu_h_q     <= '0;
            op2_h_q     <= '0;
            rd_h_q      <= '0;
            ctrl_h_q    <= '0;
            out_valid_q <= 1'b0;
            pc_out_q    <= '0;
            alu_q       <= '0;
            ld_q        <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_h_q      <= pc_h_d;
            alu_h_q     <= alu_h_d;
            op2_h_q     <= op2_h_d;
            rd_h_q      <= rd_h_d;
            ctrl_h_q    <= ctrl_h_d;
            out_valid_q <= out_valid_d;
            pc_out_q    <= pc_out_d;
            alu_q       <= alu_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
        end
    end

    // Data array is deliberately not reset; a reset edge still blocks writes.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[idx] <= src_op2;
        end
    end

    assign out_valid    = out_valid_q;
    assign pc_out       = pc_out_q;
    assign aluResult    = alu_q;
    assign ldResult     = ld_q;
    assign rd           = rd_q;
    assign ctrl_sig_reg = ctrl_q;

endmodule

// File: doc/memory_access.md
# memory_access

Memory-access (MA) stage of the five-stage core, directly upstream of write-back. Takes the EX/MA instruction (ALU result, store operand, destination register, control bundle), performs word loads/stores against an internal data memory with configurable latency, and presents a registered MA/WB bundle (`pc_out`, `aluResult`, `ldResult`, `rd`, `ctrl_sig_reg`) to write-back. A ready/valid handshake stalls upstream while a memory access is in flight.

## Interface
- `INSTR_WIDTH`, 32, datapath and PC width
- `ADDR_WIDTH`, 4, register-index width
- `DMEM_DEPTH`, 1024, data-memory words (power of 2)
- `MEM_LATENCY`, 3, cycles per load/store, ≥1

- `clk`  in  1  clock; reset is synchronous and active-high
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  EX/MA bundle valid
- `in_ready`  out  1  stage can accept; `(state==IDLE) && !rst`
- `pc_in`  in  INSTR_WIDTH  instruction PC
- `aluResult_in`  in  INSTR_WIDTH  ALU result / effective address
- `op2_in`  in  INSTR_WIDTH  store data
- `rd_in`  in  ADDR_WIDTH  destination register
- `ctrl_sig_in`  in  control_signal  package control bundle (uses `isLd`, `isSt`)
- `out_valid`  out  1  one-cycle pulse per completed instruction
- `pc_out`, `aluResult`, `ldResult`  out  INSTR_WIDTH each  registered MA/WB values
- `rd`  out  ADDR_WIDTH  registered destination
- `ctrl_sig_reg`  out  control_signal  registered control bundle

## Operation
- Accept when `in_valid && in_ready` at a rising edge; all inputs are captured into hold registers that edge; later input changes are ignored.
- Memory-op: `isLd || isSt`. Both set: treated as load, no write.
- Word index = `aluResult_in[$clog2(DMEM_DEPTH)+1:2]`; bits [1:0] ignored; upper bits ignored (wrap-around).
- FSM: IDLE, BUSY. Down-counter `cnt`, width `$clog2(MEM_LATENCY)+1`.
  - IDLE, accept of non-memory op, or memory op with MEM_LATENCY=1: complete at same edge, stay IDLE.
  - IDLE, accept of memory op with MEM_LATENCY>1: `cnt<=MEM_LATENCY-1`, go BUSY.
  - BUSY: if `cnt==1` complete, go IDLE; else `cnt<=cnt-1`.
- Completion edge: store writes `mem[idx]<=op2`; load sets `ldResult<=mem[idx]`; non-load leaves `ldResult` holding its prior value; `pc_out`, `aluResult`, `rd`, `ctrl_sig_reg` loaded from hold regs; `out_valid<=1`. Every other edge: `out_valid<=0`.
- Write-back has no backpressure; `out_valid` is never held.
- Outputs other than `out_valid` hold their last values between pulses.
- Memory array is not reset; loads from never-written words are unspecified.

## Timing
- Reset (`rst` high at edge): state IDLE, `cnt` 0, `out_valid` 0, all data outputs and `ctrl_sig_reg` 0; `in_ready` 0 while `rst` high, 1 in the first cycle after.
- Acceptance sampled at end of cycle t:
  - non-memory op: `out_valid` high in cycle t+1
  - memory op: `out_valid` high in cycle t+MEM_LATENCY; memory read/write on the edge ending cycle t+MEM_LATENCY-1
  - `in_ready` low in cycles t+1 … t+MEM_LATENCY-1.
- Throughput: one non-memory op per cycle; one memory op per MEM_LATENCY cycles.
- Store then load to same word: load returns stored data (store completes first).
- Reset while BUSY: access aborted, pending store not written, no `out_valid`.
- `in_valid` while `in_ready` low: ignored, no capture.

## Test plan
- Reset then idle: `out_valid`=0, `ldResult`=0, `in_ready`=1 the cycle after reset deasserts.
- ALU op (`pc_in`=0x40, `aluResult_in`=0x1234, `rd_in`=5, no ld/st) accepted cycle t -> cycle t+1: `out_valid`=1, `aluResult`=0x1234, `rd`=5, `pc_out`=0x40; `in_ready` stays 1.
- Store `op2_in`=0xDEADBEEF to addr 0x10, then load from 0x10 (MEM_LATENCY=3) -> `in_ready` low 2 cycles after each accept; load `out_valid` 3 cycles after its accept with `ldResult`=0xDEADBEEF.
- Address aliasing: store 0xA5A5A5A5 to 0x13 (low bits ignored), load from 0x1010 (DEPTH=1024 wraps to word 4) -> `ldResult`=0xA5A5A5A5.
- Back-to-back ALU ops held `in_valid`=1 for 4 cycles -> 4 consecutive `out_valid` pulses with matching `aluResult`.
- Reset asserted one cycle after accepting store of 0x55 to 0x20, then load 0x20 -> no `out_valid` from aborted store; memory word unchanged from its pre-store value.
